// File: rtl/alu_issue.sv
// Issue/response sequencer wrapping an external combinational ALU.
// Optional illegal-opcode fast path: define ALU_ISSUE_OPCHK_EN.

`ifndef ALU_AND
`define ALU_AND 4'b0000
`endif
`ifndef ALU_OR
`define ALU_OR  4'b0001
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0010
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0110
`endif
`ifndef ALU_SLT
`define ALU_SLT 4'b0111
`endif
`ifndef ALU_NOR
`define ALU_NOR 4'b1100
`endif

module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] op_count
);

  // state  | meaning
  // IDLE   | waiting for a request, req_ready high
  // DRIVE  | operands registered onto the ALU inputs
  // SETTLE | ALU output sampled into rsp_data
  // RESP   | result offered, waiting for rsp_ready
  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, RESP} state_t;

  state_t state, next_state;
  logic   transfer;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      `ALU_ADD, `ALU_SUB, `ALU_OR, `ALU_AND, `ALU_NOR, `ALU_SLT: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

  assign transfer = (state == IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
`ifdef ALU_ISSUE_OPCHK_EN
          next_state = op_legal(req_op) ? DRIVE : RESP;
`else
          next_state = DRIVE;
`endif
        end
      end
      DRIVE:  next_state = SETTLE;
      SETTLE: next_state = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op   <= 4'd0;
      alu_a    <= 32'd0;
      alu_b    <= 32'd0;
      rsp_data <= 32'd0;
      op_count <= 16'd0;
    end else begin
      if (transfer) begin
`ifdef ALU_ISSUE_OPCHK_EN
        // Illegal opcodes never reach the ALU; the previous drive is kept.
        if (!op_legal(req_op)) begin
          rsp_data <= 32'd0;
        end else begin
          alu_op <= req_op;
          alu_a  <= req_a;
          alu_b  <= req_b;
        end
`else
        alu_op <= req_op;
        alu_a  <= req_a;
        alu_b  <= req_b;
`endif
      end
      if (state == SETTLE) rsp_data <= alu_result;
      if (state == RESP && rsp_ready && op_count != 16'hFFFF)
        op_count <= op_count + 16'd1;
    end
  end

`ifdef ALU_ISSUE_OPCHK_EN
  always_ff @(posedge clk) begin
    if (rst)                   rsp_err <= 1'b0;
    else if (transfer)         rsp_err <= !op_legal(req_op);
    else if (state == SETTLE)  rsp_err <= 1'b0;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue; a small ALU model closes the loop on alu_result.
// Honours ALU_ISSUE_OPCHK_EN for the illegal-opcode case.

`ifndef ALU_AND
`define ALU_AND 4'b0000
`endif
`ifndef ALU_OR
`define ALU_OR  4'b0001
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0010
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0110
`endif
`ifndef ALU_SLT
`define ALU_SLT 4'b0111
`endif
`ifndef ALU_NOR
`define ALU_NOR 4'b1100
`endif

module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  alu_issue dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // External ALU: unknown opcodes produce a recognisable pattern.
  always_comb begin
    alu_result = 32'h0000F00D;
    case (alu_op)
      `ALU_ADD: alu_result = alu_a + alu_b;
      `ALU_SUB: alu_result = alu_a - alu_b;
      `ALU_AND: alu_result = alu_a & alu_b;
      `ALU_OR:  alu_result = alu_a | alu_b;
      `ALU_NOR: alu_result = ~(alu_a | alu_b);
      `ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default:  alu_result = 32'h0000F00D;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full-rate operation with rsp_ready held high; checks latency and result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data,
                        input logic [15:0] exp_count);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check({tag, " alu_a"}, alu_a, a);
    check({tag, " alu_b"}, alu_b, b);
    check({tag, " c1 rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    step();
    check({tag, " c2 rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    step();
    check({tag, " c3 rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, " rsp_data"}, rsp_data, exp_data);
    check({tag, " rsp_err"}, {31'd0, rsp_err}, 32'd0);
    step();
    check({tag, " done rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, " op_count"}, {16'd0, op_count}, {16'd0, exp_count});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
    rsp_ready = 1'b0;
    step();
    step();
    check("rst req_ready", {31'd0, req_ready}, 32'd1);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst alu_op", {28'd0, alu_op}, 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    check("rst rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst op_count", {16'd0, op_count}, 32'd0);
    rst = 1'b0;

    run_op("add", `ALU_ADD, 32'd5, 32'd3, 32'd8, 16'd1);
    run_op("sub", `ALU_SUB, 32'd0, 32'd1, 32'hFFFFFFFF, 16'd2);
    run_op("slt", `ALU_SLT, 32'd2, 32'd7, 32'd1, 16'd3);
    run_op("or",  `ALU_OR,  32'h00F0, 32'h0F00, 32'h0FF0, 16'd4);

    // Backpressure: RESP held five cycles while new requests are offered.
    req_op = `ALU_NOR; req_a = 32'd0; req_b = 32'd0; req_valid = 1'b1; rsp_ready = 1'b0;
    step();
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      req_op = `ALU_ADD; req_a = 32'd100 + 32'(i); req_valid = 1'b1;
      check("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp rsp_data", rsp_data, 32'hFFFFFFFF);
      check("bp req_ready", {31'd0, req_ready}, 32'd0);
      check("bp alu_a", alu_a, 32'd0);
      step();
    end
    check("bp still valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check("bp released", {31'd0, rsp_valid}, 32'd0);
    check("bp op_count", {16'd0, op_count}, 32'd5);

    // req_a changes while the op is in flight.
    req_op = `ALU_ADD; req_a = 32'd4; req_b = 32'd6; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    req_a = 32'd9; req_valid = 1'b1;
    check("settle alu_a", alu_a, 32'd4);
    step();
    check("settle rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("settle rsp_data", rsp_data, 32'd10);
    check("settle alu_a hold", alu_a, 32'd4);
    req_valid = 1'b0;
    step();
    check("settle op_count", {16'd0, op_count}, 32'd6);

    // Reset during SETTLE abandons the operation.
    req_op = `ALU_AND; req_a = 32'hFF; req_b = 32'h0F; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort op_count", {16'd0, op_count}, 32'd0);
    check("abort req_ready", {31'd0, req_ready}, 32'd1);
    check("abort alu_a", alu_a, 32'd0);
    step();
    check("abort quiet", {31'd0, rsp_valid}, 32'd0);

    // Illegal opcode.
    req_op = 4'hF; req_a = 32'd11; req_b = 32'd22; req_valid = 1'b1; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
`ifdef ALU_ISSUE_OPCHK_EN
    check("ill rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("ill rsp_data", rsp_data, 32'd0);
    check("ill rsp_err", {31'd0, rsp_err}, 32'd1);
    check("ill alu_a", alu_a, 32'd0);
    check("ill alu_op", {28'd0, alu_op}, 32'd0);
`else
    check("ill c1 rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    check("ill c2 rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    check("ill c3 rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("ill rsp_data", rsp_data, 32'h0000F00D);
    check("ill rsp_err", {31'd0, rsp_err}, 32'd0);
    check("ill alu_a", alu_a, 32'd11);
`endif
    step();
    check("ill done", {31'd0, rsp_valid}, 32'd0);
    check("ill op_count", {16'd0, op_count}, 32'd1);

    // A legal op afterwards must clear the error flag.
    run_op("and", `ALU_AND, 32'hF0F0, 32'h0FF0, 32'h00F0, 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
